data_mem_responder: RTL and testbench



---
 rtl/custom_types.sv | 13 +
 rtl/data_ram.sv | 25 ++
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_types.sv
// Types and widths shared between the CPU datapath and the data-memory responder.
package custom_types;

  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_ADDR_W = 8;

  typedef enum logic [1:0] {
    MR_IDLE,
    MR_WAIT,
    MR_RESP
  } mem_resp_state_t;

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM: synchronous write, asynchronous read.
// The responder registers the read word itself on the edge entering RESP.
module data_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU's MEMORY_ACCESS step: data RAM plus one GPIO register,
// answered over valid/ready with a fixed wait-state latency per access type.
module data_mem_responder
  import custom_types::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1,
  parameter logic [ADDR_W-1:0] GPIO_ADDR = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [DATA_W-1:0] gpio_out
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  RD_L  = 4'(RD_LAT);
  localparam logic [3:0]  WR_L  = 4'(WR_LAT);

  mem_resp_state_t state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              in_idle;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [3:0]        cur_lat;
  logic              hit_ram;
  logic              hit_gpio;
  logic              enter_resp;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // In IDLE the live request is used so single-cycle accesses complete on the accept edge.
  always_comb begin
    in_idle    = (state_q == MR_IDLE);
    cur_write  = in_idle ? req_write : wr_q;
    cur_addr   = in_idle ? req_addr  : addr_q;
    cur_wdata  = in_idle ? req_wdata : wdata_q;
    cur_lat    = cur_write ? WR_L : RD_L;
    hit_ram    = (32'(cur_addr) < DEPTH);
    hit_gpio   = (cur_addr == GPIO_ADDR);
    enter_resp = (in_idle && req_valid && (cur_lat == 4'd1)) ||
                 ((state_q == MR_WAIT) && (cnt_q == 4'd1));
    ram_we     = enter_resp && cur_write && hit_ram;
    ram_addr   = hit_ram ? cur_addr[IDX_W-1:0] : '0;
  end

  assign req_ready = in_idle;

  data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MR_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      gpio_out   <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= !(hit_ram || hit_gpio);
        if (cur_write) begin
          resp_rdata <= '0;
          if (hit_gpio) begin
            gpio_out <= cur_wdata;
          end
        end else if (hit_ram) begin
          resp_rdata <= ram_rdata;
        end else if (hit_gpio) begin
          resp_rdata <= gpio_out;
        end else begin
          resp_rdata <= '0;
        end
      end

      unique case (state_q)
        MR_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= cur_lat - 4'd1;
            state_q <= (cur_lat == 4'd1) ? MR_RESP : MR_WAIT;
          end
        end
        MR_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= MR_RESP;
          end
        end
        MR_RESP: state_q <= MR_IDLE;
        default: state_q <= MR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Two responders (RD_LAT=2/WR_LAT=1 and RD_LAT=1/WR_LAT=3) against a deadline-based
// transaction model, plus directed literal checks.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       rv [2];
  logic       rw [2];
  logic [7:0] ra [2];
  logic [7:0] rwd [2];
  logic       rdy [2];
  logic       resp_v [2];
  logic [7:0] rrd [2];
  logic       rerr [2];
  logic [7:0] gpio [2];

  int rl [2] = '{2, 1};
  int wl [2] = '{1, 3};

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.RD_LAT(2), .WR_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .resp_valid(resp_v[0]), .resp_rdata(rrd[0]),
    .resp_err(rerr[0]), .gpio_out(gpio[0])
  );

  data_mem_responder #(.RD_LAT(1), .WR_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .resp_valid(resp_v[1]), .resp_rdata(rrd[1]),
    .resp_err(rerr[1]), .gpio_out(gpio[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted access completes at a deadline edge, then one idle-bound response cycle.
  logic [7:0] m_mem [2][128];
  bit         m_known [2][128];
  logic [7:0] m_gpio [2];
  bit         m_busy [2];
  bit         m_inresp [2];
  longint     m_done [2];
  bit         m_wr [2];
  logic [7:0] m_a [2];
  logic [7:0] m_wd [2];
  bit         e_valid [2];
  bit         e_err [2];
  bit         e_known [2];
  logic [7:0] e_rdata [2];
  longint     edge_n = 0;

  task automatic perform(input int d);
    e_valid[d]  = 1;
    m_inresp[d] = 1;
    e_err[d]    = 0;
    e_known[d]  = 1;
    e_rdata[d]  = 8'h00;
    if (m_a[d] < 8'd128) begin
      if (m_wr[d]) begin
        m_mem[d][m_a[d]]   = m_wd[d];
        m_known[d][m_a[d]] = 1;
      end else begin
        e_rdata[d] = m_mem[d][m_a[d]];
        e_known[d] = m_known[d][m_a[d]];
      end
    end else if (m_a[d] == 8'hFF) begin
      if (m_wr[d]) m_gpio[d] = m_wd[d];
      else         e_rdata[d] = m_gpio[d];
    end else begin
      e_err[d] = 1;
    end
  endtask

  task automatic model_step(input int d);
    int lat;
    e_valid[d] = 0;
    if (reset) begin
      m_busy[d] = 0; m_inresp[d] = 0; m_gpio[d] = 8'h00;
      e_rdata[d] = 8'h00; e_err[d] = 0; e_known[d] = 1;
    end else if (m_busy[d]) begin
      if (edge_n == m_done[d]) begin
        m_busy[d] = 0;
        perform(d);
      end
    end else if (m_inresp[d]) begin
      m_inresp[d] = 0;
    end else if (rv[d] === 1'b1) begin
      m_wr[d] = rw[d]; m_a[d] = ra[d]; m_wd[d] = rwd[d];
      lat = rw[d] ? wl[d] : rl[d];
      m_done[d] = edge_n + lat - 1;
      if (lat == 1) perform(d);
      else          m_busy[d] = 1;
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    model_step(0);
    model_step(1);
    #1;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready%0d", d), rdy[d], !(m_busy[d] || m_inresp[d]));
        chk($sformatf("resp_valid%0d", d), resp_v[d], e_valid[d]);
        chk($sformatf("gpio%0d", d), gpio[d], m_gpio[d]);
        if (e_valid[d]) begin
          chk($sformatf("resp_err%0d", d), rerr[d], e_err[d]);
          if (e_known[d]) chk($sformatf("resp_rdata%0d", d), rrd[d], e_rdata[d]);
        end
      end
    end
  end

  task automatic do_req(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output logic er, output logic [7:0] g,
                        output int cyc);
    cyc = 0; rd = 8'h00; er = 1'b0; g = 8'h00;
    @(negedge clk);
    rv[d] = 1'b1; rw[d] = w; ra[d] = a; rwd[d] = wd;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (i == 1) rv[d] = 1'b0;
      if (resp_v[d] === 1'b1) begin
        cyc = i; rd = rrd[d]; er = rerr[d]; g = gpio[d];
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
  endtask

  logic [7:0] rd, g;
  logic       er;
  int         cyc;
  int         seen;

  task automatic rand_drive(input bit always_valid);
    int r;
    for (int d = 0; d < 2; d++) begin
      rv[d] = always_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
      rw[d] = 1'($urandom_range(0, 1));
      rwd[d] = 8'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0)      ra[d] = 8'h7F;
      else if (r == 1) ra[d] = 8'hFF;
      else if (r == 2) ra[d] = 8'(8'h80 + $urandom_range(0, 126));
      else             ra[d] = 8'($urandom_range(0, 127));
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 0; rw[d] = 0; ra[d] = 0; rwd[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", rdy[d], 1);
      chk("rst_resp_valid", resp_v[d], 0);
      chk("rst_gpio", gpio[d], 8'h00);
      chk("rst_rdata", rrd[d], 8'h00);
      chk("rst_err", rerr[d], 0);
    end

    do_req(0, 1, 8'h10, 8'hA5, rd, er, g, cyc);
    chk("st_ram_lat", cyc, 1);  chk("st_ram_err", er, 0);
    do_req(0, 0, 8'h10, 8'h00, rd, er, g, cyc);
    chk("ld_ram_lat", cyc, 2);  chk("ld_ram_data", rd, 8'hA5); chk("ld_ram_err", er, 0);
    do_req(0, 1, 8'hFF, 8'h3C, rd, er, g, cyc);
    chk("st_gpio_val", g, 8'h3C); chk("st_gpio_rdata", rd, 8'h00);
    do_req(0, 0, 8'hFF, 8'h00, rd, er, g, cyc);
    chk("ld_gpio", rd, 8'h3C);
    do_req(0, 1, 8'h00, 8'h11, rd, er, g, cyc);
    do_req(0, 1, 8'h80, 8'h77, rd, er, g, cyc);
    chk("st_err_lat", cyc, 1);  chk("st_err", er, 1);
    do_req(0, 0, 8'h80, 8'h00, rd, er, g, cyc);
    chk("ld_err_lat", cyc, 2);  chk("ld_err", er, 1); chk("ld_err_rdata", rd, 8'h00);
    do_req(0, 0, 8'h00, 8'h00, rd, er, g, cyc);
    chk("no_alias_ram0", rd, 8'h11); chk("no_alias_gpio", g, 8'h3C);
    do_req(0, 1, 8'h7F, 8'h5A, rd, er, g, cyc);
    do_req(0, 0, 8'h7F, 8'h00, rd, er, g, cyc);
    chk("ld_last_word", rd, 8'h5A); chk("ld_last_err", er, 0);

    do_req(1, 1, 8'h20, 8'hA5, rd, er, g, cyc);
    chk("st_wl3_lat", cyc, 3);
    do_req(1, 0, 8'h20, 8'h00, rd, er, g, cyc);
    chk("ld_rl1_lat", cyc, 1);  chk("ld_rl1_data", rd, 8'hA5);

    // Store aborted by reset one cycle after accept.
    seen = 0;
    @(negedge clk);
    rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 8'h20; rwd[1] = 8'hEE;
    @(posedge clk);
    #1 rv[1] = 1'b0;
    if (resp_v[1] === 1'b1) seen++;
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_v[1] !== 1'b0) seen++;
    end
    @(negedge clk) reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_v[1] !== 1'b0) seen++;
    end
    chk("abort_no_resp", seen, 0);
    do_req(1, 0, 8'h20, 8'h00, rd, er, g, cyc);
    chk("abort_ram_kept", rd, 8'hA5);
    chk("abort_gpio_reset", gpio[0], 8'h00);

    repeat (200) begin
      @(negedge clk);
      rand_drive(1'b1);
    end
    repeat (300) begin
      @(negedge clk);
      rand_drive(1'b0);
    end
    @(negedge clk);
    rv[0] = 0; rv[1] = 0;
    repeat (6) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
